// File: rtl/sram_match_scheduler_if.sv
// Signal bundle between the port ingress/matcher array (master) and the
// SRAM match scheduler (slave).
interface sram_match_scheduler_if;
  logic [15:0] match_req;
  logic [15:0] unbind_req;
  logic [15:0] match_end;
  logic [79:0] matched_sram;
  logic [15:0] match_enable;
  logic [3:0]  cnt_16;
  logic [15:0] bound_valid;
  logic [79:0] bound_sram;
  logic [31:0] sram_occupied;
  logic [15:0] conflict;
  logic [15:0] timeout;

  modport master (
    output match_req, unbind_req, match_end, matched_sram,
    input  match_enable, cnt_16, bound_valid, bound_sram, sram_occupied,
           conflict, timeout
  );

  modport slave (
    input  match_req, unbind_req, match_end, matched_sram,
    output match_enable, cnt_16, bound_valid, bound_sram, sram_occupied,
           conflict, timeout
  );
endinterface

// File: rtl/sram_match_scheduler.sv
// Round-robin launch scheduler for the 16 per-port SRAM matchers; owns the
// port-to-SRAM binding table and the SRAM occupancy vector.
module sram_match_scheduler #(
  parameter int MAX_ACTIVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_match_scheduler_if.slave bus
);
  localparam int         NPORT    = 16;
  localparam int         NSRAM    = 32;
  localparam logic [7:0] AGE_LAST = 8'(TIMEOUT - 1);

  logic [3:0]       rr_ptr;
  logic [7:0]       age [NPORT];
  logic [NPORT-1:0] cooldown;

  logic [NPORT-1:0] eligible;
  logic             grant_vld;
  logic [3:0]       grant_idx;
  logic [3:0]       scan_idx;
  logic [NPORT-1:0] grant_onehot;

  logic [NPORT-1:0] unbind_ok;
  logic [NPORT-1:0] done;
  logic [NPORT-1:0] commit;
  logic [NPORT-1:0] reject;
  logic [NPORT-1:0] expire;
  logic [NSRAM-1:0] unbind_mask;
  logic [NSRAM-1:0] claimed;
  logic [4:0]       sel;

  // The session count includes sessions ending this cycle, so a slot freed
  // now is only reused on the following cycle.
  always_comb begin
    eligible     = bus.match_req & ~bus.bound_valid & ~bus.match_enable & ~cooldown;
    grant_vld    = 1'b0;
    grant_idx    = '0;
    scan_idx     = '0;
    grant_onehot = '0;
    if ($countones(bus.match_enable) < MAX_ACTIVE) begin
      for (int i = 0; i < NPORT; i++) begin
        scan_idx = rr_ptr + 4'(i);
        if (!grant_vld && eligible[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_vld) grant_onehot[grant_idx] = 1'b1;
  end

  always_comb begin
    unbind_ok   = bus.unbind_req & bus.bound_valid;
    unbind_mask = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (unbind_ok[p]) unbind_mask[bus.bound_sram[5*p +: 5]] = 1'b1;
    end
  end

  // Commits are resolved in ascending port order: an SRAM freed by an unbind
  // this cycle is available, and the first claimant wins.
  always_comb begin
    done    = bus.match_end & bus.match_enable;
    commit  = '0;
    reject  = '0;
    expire  = '0;
    claimed = '0;
    sel     = '0;
    for (int p = 0; p < NPORT; p++) begin
      sel = bus.matched_sram[5*p +: 5];
      if (done[p]) begin
        if ((bus.sram_occupied[sel] && !unbind_mask[sel]) || claimed[sel]) begin
          reject[p] = 1'b1;
        end else begin
          commit[p]    = 1'b1;
          claimed[sel] = 1'b1;
        end
      end
      if (bus.match_enable[p] && !bus.match_end[p] && age[p] == AGE_LAST)
        expire[p] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cnt_16        <= '0;
      bus.match_enable  <= '0;
      bus.bound_valid   <= '0;
      bus.bound_sram    <= '0;
      bus.sram_occupied <= '0;
      bus.conflict      <= '0;
      bus.timeout       <= '0;
      rr_ptr            <= '0;
      cooldown          <= '0;
      for (int p = 0; p < NPORT; p++) age[p] <= '0;
    end else begin
      bus.cnt_16        <= bus.cnt_16 + 4'd1;
      bus.match_enable  <= (bus.match_enable & ~(commit | reject | expire)) | grant_onehot;
      bus.bound_valid   <= (bus.bound_valid & ~unbind_ok) | commit;
      bus.sram_occupied <= (bus.sram_occupied & ~unbind_mask) | claimed;
      bus.conflict      <= reject;
      bus.timeout       <= expire;
      cooldown          <= commit | reject | expire;
      if (grant_vld) rr_ptr <= grant_idx + 4'd1;
      for (int p = 0; p < NPORT; p++) begin
        if (commit[p]) bus.bound_sram[5*p +: 5] <= bus.matched_sram[5*p +: 5];
        if (grant_onehot[p])
          age[p] <= '0;
        else if (bus.match_enable[p])
          age[p] <= age[p] + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_sram_match_scheduler.sv
// Directed bench: stimulus pushes expected grant/bind/conflict/timeout events
// with their due cycle; a negedge monitor matches observed events against them.
module tb_sram_match_scheduler;
  localparam int K_GRANT = 0;
  localparam int K_BIND  = 1;
  localparam int K_CONF  = 2;
  localparam int K_TOUT  = 3;

  typedef struct {
    int kind;
    int port;
    int sram;
    int cyc;
  } ev_t;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  ev_t         exp_q[$];
  logic [15:0] prev_en  = '0;
  logic [15:0] prev_bv  = '0;

  sram_match_scheduler_if bus();

  sram_match_scheduler #(.MAX_ACTIVE(4), .TIMEOUT(20)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_GRANT: return "grant";
      K_BIND:  return "bind";
      K_CONF:  return "conflict";
      default: return "timeout";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic expect_ev(input int kind, input int port, input int sram, input int due);
    ev_t e;
    e.kind = kind;
    e.port = port;
    e.sram = sram;
    e.cyc  = due;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int port, input int sram);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].port == port) idx = i;
    if (idx < 0) begin
      n_checks++;
      $display("FAIL unexpected_%s: port %0d sram %0d at cycle %0d, none required",
               kname(kind), port, sram, cyc);
    end else begin
      check($sformatf("%s_p%0d_cycle", kname(kind), port), 32'(cyc), 32'(exp_q[idx].cyc));
      if (kind == K_BIND)
        check($sformatf("bind_p%0d_sram", port), 32'(sram), 32'(exp_q[idx].sram));
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 16; p++) begin
      if (bus.match_enable[p] && !prev_en[p]) observe(K_GRANT, p, 0);
      if (bus.bound_valid[p] && !prev_bv[p]) observe(K_BIND, p, int'(bus.bound_sram[5*p +: 5]));
      if (bus.conflict[p]) observe(K_CONF, p, 0);
      if (bus.timeout[p]) observe(K_TOUT, p, 0);
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        n_checks++;
        $display("FAIL missing_%s: port %0d due cycle %0d, not seen by cycle %0d",
                 kname(exp_q[i].kind), exp_q[i].port, exp_q[i].cyc, cyc);
        exp_q.delete(i);
      end
    end
    prev_en <= bus.match_enable;
    prev_bv <= bus.bound_valid;
  end

  // Pulse inputs default low every cycle; callers raise them after the tick.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.match_end  = '0;
    bus.unbind_req = '0;
  endtask

  initial begin
    int a, b, c, d, e, cnt;
    bus.match_req    = '0;
    bus.unbind_req   = '0;
    bus.match_end    = '0;
    bus.matched_sram = '0;
    rst_n            = 1'b0;
    repeat (3) tick();

    // Reset state and free-running slot counter
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_match_enable", 32'(bus.match_enable), 32'h0);
    check("rst_cnt_16", 32'(bus.cnt_16), 32'h0);
    check("rst_bound_valid", 32'(bus.bound_valid), 32'h0);
    check("rst_bound_sram_any", 32'(|bus.bound_sram), 32'h0);
    check("rst_sram_occupied", bus.sram_occupied, 32'h0);
    check("rst_conflict", 32'(bus.conflict), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("cnt_16_step%0d", i), 32'(bus.cnt_16), 32'(i % 16));
    end

    // Port 3 alone, matcher answers SRAM 7 five cycles after enable
    tick();
    a = cyc;
    bus.match_req = 16'h0008;
    expect_ev(K_GRANT, 3, 0, a + 1);
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) begin
        bus.match_end[3]          = 1'b1;
        bus.matched_sram[19:15]   = 5'd7;
        expect_ev(K_BIND, 3, 7, a + 7);
      end
      @(negedge clk);
      if (bus.match_enable[3]) cnt++;
    end
    check("p3_enable_cycles", 32'(cnt), 32'd6);
    check("p3_bound_valid", 32'(bus.bound_valid), 32'h0008);
    check("p3_bound_sram", 32'(bus.bound_sram[19:15]), 32'd7);
    check("p3_sram_occupied", bus.sram_occupied, 32'h0000_0080);

    // Unbind of port 3 and commit of the same SRAM by port 6 in one cycle
    tick();
    e = cyc;
    bus.match_req = 16'h0040;
    expect_ev(K_GRANT, 6, 0, e + 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) begin
        bus.unbind_req[3]        = 1'b1;
        bus.match_end[6]         = 1'b1;
        bus.matched_sram[34:30]  = 5'd7;
        bus.match_req            = '0;
        expect_ev(K_BIND, 6, 7, e + 4);
      end
      @(negedge clk);
    end
    check("swap_bound_valid", 32'(bus.bound_valid), 32'h0040);
    check("swap_sram_occupied", bus.sram_occupied, 32'h0000_0080);
    check("swap_p3_stale_sram", 32'(bus.bound_sram[19:15]), 32'd7);

    // Ports 2 and 5 finish together on SRAM 9
    tick();
    b = cyc;
    bus.match_req = 16'h0024;
    expect_ev(K_GRANT, 2, 0, b + 1);
    expect_ev(K_GRANT, 5, 0, b + 2);
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 3) begin
        bus.match_end[2]         = 1'b1;
        bus.match_end[5]         = 1'b1;
        bus.matched_sram[14:10]  = 5'd9;
        bus.matched_sram[29:25]  = 5'd9;
        expect_ev(K_BIND, 2, 9, b + 4);
        expect_ev(K_CONF, 5, 0, b + 4);
        expect_ev(K_GRANT, 5, 0, b + 6);
      end
      @(negedge clk);
      if (i == 4) begin
        check("tie_bound_valid", 32'(bus.bound_valid), 32'h0044);
        check("tie_sram_occupied", bus.sram_occupied, 32'h0000_0280);
        check("tie_p5_enable_low", 32'(bus.match_enable[5]), 32'h0);
      end
    end

    // Reset with port 5 mid-session
    tick();
    rst_n = 1'b0;
    bus.match_req = '0;
    tick();
    @(negedge clk);
    check("midrst_match_enable", 32'(bus.match_enable), 32'h0);
    check("midrst_bound_valid", 32'(bus.bound_valid), 32'h0);
    check("midrst_sram_occupied", bus.sram_occupied, 32'h0);
    tick();
    rst_n = 1'b1;

    // All ports request; session cap of four
    tick();
    c = cyc;
    bus.match_req = 16'hFFFF;
    for (int p = 0; p < 4; p++) expect_ev(K_GRANT, p, 0, c + 1 + p);
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 8) begin
        bus.match_end[1]      = 1'b1;
        bus.matched_sram[9:5] = 5'd1;
        expect_ev(K_BIND, 1, 1, c + 9);
        expect_ev(K_GRANT, 4, 0, c + 10);
      end
      @(negedge clk);
      if (i == 7) check("cap_enable_set", 32'(bus.match_enable), 32'h000F);
    end
    check("cap_after_refill", 32'(bus.match_enable), 32'h001D);

    tick();
    rst_n = 1'b0;
    bus.match_req = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Silent matcher on port 6: timeout, cooldown, regrant
    tick();
    d = cyc;
    bus.match_req = 16'h0040;
    expect_ev(K_GRANT, 6, 0, d + 1);
    expect_ev(K_TOUT, 6, 0, d + 21);
    expect_ev(K_GRANT, 6, 0, d + 23);
    cnt = 0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      @(negedge clk);
      if (bus.match_enable[6]) cnt++;
    end
    check("tout_enable_cycles", 32'(cnt), 32'd20);
    tick();
    @(negedge clk);
    check("tout_regrant_enable", 32'(bus.match_enable), 32'h0040);

    tick();
    rst_n = 1'b0;
    bus.match_req = '0;
    tick();
    tick();
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_match_scheduler.md
# sram_match_scheduler

Central scheduler for the 16 per-port SRAM matchers of the switch. Serializes match launches with a round-robin grant, caps concurrent matching sessions, and drives the shared `cnt_16` slot counter. Commits each finished match into a port→SRAM binding table and rejects SRAMs that another port already owns. Sits between the port ingress logic, which requests SRAMs, and the matcher array. The SRAM allocator reads its occupancy vector.

## Interface
- `MAX_ACTIVE`, default 4: maximum matching sessions in flight (1..16).
- `TIMEOUT`, default 64: cycles a session may run before it is aborted (2..255).

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `match_req` input 16: level, port p needs an SRAM.
- `unbind_req` input 16: pulse, port p releases its bound SRAM.
- `match_end` input 16: from matcher p, high for one cycle when its match completes.
- `matched_sram` input 80: matcher p result in bits [5p+4:5p], valid with `match_end[p]`.
- `match_enable` output 16: to matcher p, session active.
- `cnt_16` output 4: free-running slot counter broadcast to all matchers.
- `bound_valid` output 16: port p owns an SRAM.
- `bound_sram` output 80: port p's SRAM in bits [5p+4:5p].
- `sram_occupied` output 32: bit s set while SRAM s is bound to any port.
- `conflict` output 16: one-cycle pulse, match of p rejected because its SRAM is occupied.
- `timeout` output 16: one-cycle pulse, session of p aborted.

## Operation
- `cnt_16` increments every cycle and wraps 15→0.
- Port p is eligible when all of the following hold:
  - `match_req[p]` = 1
  - `bound_valid[p]` = 0
  - `match_enable[p]` = 0
  - p is not in its post-session cooldown cycle
- Grant:
  - At most one grant per cycle, and only when active sessions < `MAX_ACTIVE`.
  - The winner is the first eligible port at or after `rr_ptr`, scanning upward modulo 16.
  - On a grant, `rr_ptr` ← winner+1, wrapping 15→0.
- A granted port's `match_enable[p]` is set, and its per-port 8-bit age counter clears and then increments each cycle.
- Completion (`match_end[p]` while `match_enable[p]` = 1) with s = matched_sram[p]:
  - s is free after this cycle's unbinds, and no lower-index port commits s in the same cycle: bind. `bound_valid[p]` ← 1, `bound_sram[p]` ← s, `sram_occupied[s]` ← 1.
  - Otherwise: pulse `conflict[p]`. p becomes eligible again after cooldown.
- Timeout: when age reaches `TIMEOUT`-1 with no `match_end`, pulse `timeout[p]`. p becomes eligible again after cooldown.
- Every session end (bind, conflict or timeout) clears `match_enable[p]` and imposes one cooldown cycle, so the matcher returns to idle.
- Unbind: `unbind_req[p]` with `bound_valid[p]` = 1 clears `bound_valid[p]` and `sram_occupied[bound_sram[p]]`. `bound_sram[p]` is kept at its stale value. Unbind with `bound_valid[p]` = 0 is ignored.
- A `match_end` without `match_enable` is ignored.
- Dropping `match_req` mid-session does not abort the session.

## Timing
- Reset values, all outputs: `match_enable` 0, `cnt_16` 0, `bound_valid` 0, `bound_sram` 0, `sram_occupied` 0, `conflict` 0, `timeout` 0. Also `rr_ptr` 0 and all age counters 0.
- Reset asserted mid-session drops every enable and binding on the next edge.
- Grant decided in cycle t → `match_enable[p]` high from t+1.
- `match_end[p]` in cycle t:
  - `bound_*`, `sram_occupied` and `conflict` update at t+1.
  - `match_enable[p]` low at t+1.
  - Earliest regrant decision at t+2, with enable high at t+3.
- Timeout: enable is high for exactly `TIMEOUT` cycles. The `timeout` pulse coincides with the first low cycle of enable.
- The active-session count used for the grant in cycle t includes sessions ending in cycle t, so the count is conservative by one cycle.
- Simultaneous unbind of SRAM s and commit of s in the same cycle: the commit succeeds.
- Simultaneous commits of the same s: the lowest port index wins, and all others pulse `conflict`.

## Test plan
- Reset, then idle for 20 cycles:
  - All outputs are 0 on the cycle after reset.
  - `cnt_16` counts 0..15 and then wraps to 0.
- Single request, port 3; `match_end[3]` with sram 7 arrives five cycles after enable rises:
  - `match_enable[3]` is high for 6 cycles.
  - Then `bound_valid[3]`=1, `bound_sram[3]`=7, `sram_occupied`=0x80.
  - `match_req[3]` held high causes no regrant.
- Ports 2 and 5 assert `match_end` in the same cycle, both with sram 9:
  - Port 2 binds 9.
  - `conflict[5]` pulses.
  - `match_enable[5]` reasserts no earlier than 3 cycles later.
- All 16 ports request with `MAX_ACTIVE`=4 and no `match_end`:
  - Grants go to ports 0, 1, 2, 3 on consecutive cycles.
  - No fifth grant occurs until a session ends.
  - After port 1 ends, the next grant goes to port 4.
- `TIMEOUT`=20, port 6 granted, matcher silent:
  - Enable is high for 20 cycles.
  - `timeout[6]` pulses.
  - Port 6 is regranted after the cooldown cycle.
- Port 3 bound to 7:
  - `unbind_req[3]` and `match_end[6]` with sram 7 in the same cycle: `bound_valid[3]`=0 and port 6 binds 7, with `sram_occupied[7]` staying 1.
